// File: rtl/edge_threshold_pkg.sv
// edge_threshold_pkg: shared image geometry, word types and FSM state encoding for the edge threshold stage
package edge_pkg;
    localparam int IMG_W         = 352;
    localparam int IMG_H         = 288;
    localparam int WORDS_PER_ROW = 88;
    localparam int IMG_WORDS     = 25344;
    localparam int RES_BASE      = 25344;
    typedef logic [31:0] word_t;
    typedef logic [15:0] halfword_t;
    typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} thr_state_t;
endpackage

// File: rtl/edge_threshold_if.sv
// edge_threshold_if: shared memory port plus start/finish handshake of the edge threshold stage
interface edge_threshold_if;
    import edge_pkg::*;
    halfword_t   addr;
    word_t       dataR;
    word_t       dataW;
    logic        en;
    logic        we;
    logic        start;
    logic [7:0]  thr;
    logic        finish;
    logic [16:0] edge_count;
    modport master(output addr, dataW, en, we, finish, edge_count, input dataR, start, thr);
    modport slave(input addr, dataW, en, we, finish, edge_count, output dataR, start, thr);
endinterface

// File: rtl/edge_threshold_word.sv
// thr_word: binarises the four pixels of a word against a threshold and counts the hits
module thr_word
    import edge_pkg::*;
(
    input  word_t      word,
    input  logic [7:0] thr,
    output word_t      bin,
    output logic [2:0] hits
);
    logic [3:0] hit;
    for (genvar b = 0; b < 4; b++) begin : g_pix
        assign hit[b]          = word[8*b +: 8] >= thr;
        assign bin[8*b +: 8]   = {8{hit[b]}};
    end
    assign hits = 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
endmodule

// File: rtl/edge_threshold.sv
// edge_threshold: binarises an edge-magnitude image in shared memory and counts edge pixels
module edge_threshold
    import edge_pkg::*;
#(
    parameter int SRC_BASE  = RES_BASE,
    parameter int DST_BASE  = RES_BASE,
    parameter int NUM_WORDS = IMG_WORDS
) (
    input logic clk,
    input logic reset,
    edge_threshold_if.master bus
);
    if (NUM_WORDS < 1 || NUM_WORDS > 32767 || SRC_BASE + NUM_WORDS > 65536 || DST_BASE + NUM_WORDS > 65536) begin : g_bad_params
        $error("edge_threshold: word count or address range out of bounds");
    end
    thr_state_t  state, nxt;
    logic [14:0] i, i_n;
    logic [7:0]  thr_q;
    logic [2:0]  hits_q, hits;
    word_t       bin;
    logic        last;
    assign last = i == 15'(NUM_WORDS - 1);
    assign i_n  = state == IDLE ? 15'd0 : (state == WRITE && !last) ? i + 15'd1 : i;
    thr_word u_word (.word(bus.dataR), .thr(thr_q), .bin(bin), .hits(hits));
    always_ff @(posedge clk)
        state <= reset ? IDLE : nxt;
    always_comb begin
        nxt = state == IDLE  ? (bus.start ? READ : IDLE) :
              state == READ  ? LATCH :
              state == LATCH ? WRITE :
              state == WRITE ? (last ? DONE : READ) :
                               (bus.start ? DONE : IDLE);
    end
    // Bus outputs are registered from the next state so they are valid for the whole state cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.addr       <= '0;
            bus.dataW      <= '0;
            bus.en         <= 1'b0;
            bus.we         <= 1'b0;
            bus.finish     <= 1'b0;
            bus.edge_count <= '0;
            i              <= '0;
            thr_q          <= '0;
            hits_q         <= '0;
        end else begin
            i          <= i_n;
            bus.en     <= nxt == READ || nxt == WRITE;
            bus.we     <= nxt == WRITE;
            bus.finish <= nxt == DONE;
            if (nxt == READ || nxt == WRITE)
                bus.addr <= halfword_t'(nxt == WRITE ? DST_BASE : SRC_BASE) + halfword_t'(i_n);
            if (state == IDLE && bus.start) begin
                thr_q          <= bus.thr;
                bus.edge_count <= '0;
            end
            if (state == LATCH) begin
                bus.dataW <= bin;
                hits_q    <= hits;
            end
            if (state == WRITE)
                bus.edge_count <= bus.edge_count + 17'(hits_q);
        end
    end
endmodule

// File: tb/tb_edge_threshold.sv
// tb_edge_threshold: directed checks of a 4-word in-place run and a full 352x288 image run
module tb_edge_threshold;
    import edge_pkg::*;
    localparam word_t SENT = 32'hDEADBEEF;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    edge_threshold_if bs();
    edge_threshold_if bb();
    edge_threshold #(.SRC_BASE(100), .DST_BASE(100), .NUM_WORDS(4)) dut_s (.clk(clk), .reset(reset), .bus(bs.master));
    edge_threshold dut_b (.clk(clk), .reset(reset), .bus(bb.master));
    word_t mem_s [256];
    word_t mem_b [65536];
    word_t ld_w [4];
    logic  ld_s = 1'b0;
    logic  ld_b = 1'b0;
    int    total = 0;
    int    bad = 0;

    function automatic word_t pat(input int k);
        return word_t'(k * 32'h9E3779B9) ^ word_t'(k << 13);
    endfunction

    function automatic word_t expw(input word_t w, input logic [7:0] t);
        word_t r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = (w[8*b +: 8] >= t) ? 8'hFF : 8'h00;
        return r;
    endfunction

    always @(posedge clk) begin
        if (ld_s) begin
            for (int k = 0; k < 4; k++) mem_s[100 + k] <= ld_w[k];
            mem_s[99]  <= SENT;
            mem_s[104] <= SENT;
        end
        if (bs.en && bs.we) mem_s[bs.addr[7:0]] <= bs.dataW;
        if (bs.en && !bs.we) bs.dataR <= mem_s[bs.addr[7:0]];
    end

    always @(posedge clk) begin
        if (ld_b) begin
            for (int k = 0; k < IMG_WORDS; k++) mem_b[RES_BASE + k] <= pat(k);
            mem_b[RES_BASE - 1]         <= SENT;
            mem_b[RES_BASE + IMG_WORDS] <= SENT;
        end
        if (bb.en && bb.we) mem_b[bb.addr] <= bb.dataW;
        if (bb.en && !bb.we) bb.dataR <= mem_b[bb.addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input word_t a, input word_t b, input word_t c, input word_t d);
        ld_w[0] = a; ld_w[1] = b; ld_w[2] = c; ld_w[3] = d;
        ld_s = 1'b1;
        tick();
        ld_s = 1'b0;
    endtask

    // Raises start with threshold t, switches thr to t2 after the first edge, waits for finish.
    task automatic run_small(input logic [7:0] t, input logic [7:0] t2, output int n);
        bs.thr = t;
        bs.start = 1'b1;
        tick();
        n = 1;
        bs.thr = t2;
        while (!bs.finish && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic stop_small();
        bs.start = 1'b0;
        tick();
    endtask

    task automatic check_mem4(input string name, input word_t a, input word_t b, input word_t c, input word_t d);
        word_t e [4];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem_s[100 + k] !== e[k]) begin
                bad++;
                $display("FAIL %s word%0d: got %h want %h", name, k, mem_s[100 + k], e[k]);
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if ({bs.en, bs.we, bs.finish} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000", {bs.en, bs.we, bs.finish});
        end
        total++;
        if (bs.addr !== 16'd0 || bs.dataW !== 32'd0) begin
            bad++;
            $display("FAIL reset_bus: got addr %h dataW %h want 0 0", bs.addr, bs.dataW);
        end
        total++;
        if (bs.edge_count !== 17'd0 || bb.edge_count !== 17'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d/%0d want 0", bs.edge_count, bb.edge_count);
        end
    endtask

    task automatic test_basic();
        int n;
        load4(32'h807FFF00, 32'h807FFF00, 32'h807FFF00, 32'h807FFF00);
        run_small(8'd128, 8'd0, n);
        total++;
        if (n !== 13) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 13", n);
        end
        total++;
        if (bs.edge_count !== 17'd8) begin
            bad++;
            $display("FAIL basic_count: got %0d want 8", bs.edge_count);
        end
        check_mem4("basic", 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00);
        total++;
        if (mem_s[99] !== SENT || mem_s[104] !== SENT) begin
            bad++;
            $display("FAIL basic_bounds: got %h %h want %h", mem_s[99], mem_s[104], SENT);
        end
        stop_small();
    endtask

    task automatic test_thresholds();
        int n;
        load4(32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h01800001);
        run_small(8'd0, 8'd0, n);
        total++;
        if (bs.edge_count !== 17'd16) begin
            bad++;
            $display("FAIL thr0_count: got %0d want 16", bs.edge_count);
        end
        check_mem4("thr0", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        stop_small();
        load4(32'hFEFEFEFE, 32'hFEFEFEFE, 32'hFEFEFEFE, 32'hFEFEFEFE);
        run_small(8'd255, 8'd255, n);
        total++;
        if (bs.edge_count !== 17'd0) begin
            bad++;
            $display("FAIL thr255_count: got %0d want 0", bs.edge_count);
        end
        check_mem4("thr255", 32'h0, 32'h0, 32'h0, 32'h0);
        stop_small();
        load4(32'h0F101100, 32'hFFFFFFFF, 32'h00000000, 32'h10101010);
        run_small(8'd16, 8'd200, n);
        total++;
        if (bs.edge_count !== 17'd10) begin
            bad++;
            $display("FAIL thr16_count: got %0d want 10", bs.edge_count);
        end
        check_mem4("thr16", 32'h00FFFF00, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
        stop_small();
    endtask

    task automatic test_bus_sequence();
        int errs = 0;
        logic [18:0] got, want;
        load4(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
        bs.thr = 8'd8;
        bs.start = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int p = 0; p < 3; p++) begin
                tick();
                got  = {bs.en, bs.we, bs.finish, bs.addr};
                want = p == 0 ? {3'b100, 16'(100 + w)} : p == 1 ? {3'b000, bs.addr} : {3'b110, 16'(100 + w)};
                if (got !== want) begin
                    errs++;
                    $display("FAIL bus_seq w%0d p%0d: got %h want %h", w, p, got, want);
                end
            end
        end
        total++;
        if (errs != 0) bad++;
        tick();
        total++;
        if ({bs.finish, bs.en} !== 2'b10) begin
            bad++;
            $display("FAIL bus_seq_done: got finish/en %b want 10", {bs.finish, bs.en});
        end
        total++;
        if (bs.edge_count !== 17'd9) begin
            bad++;
            $display("FAIL bus_seq_count: got %0d want 9", bs.edge_count);
        end
        stop_small();
    endtask

    task automatic test_reset_mid_run();
        int n;
        load4(32'h807FFF00, 32'h807FFF00, 32'h807FFF00, 32'h807FFF00);
        bs.thr = 8'd128;
        bs.start = 1'b1;
        repeat (7) tick();
        bs.start = 1'b0;
        total++;
        if (bs.edge_count !== 17'd4 || bs.addr !== 16'd102 || bs.en !== 1'b1) begin
            bad++;
            $display("FAIL mid_state: got count %0d addr %0d en %b want 4 102 1", bs.edge_count, bs.addr, bs.en);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({bs.en, bs.finish} !== 2'b00 || bs.edge_count !== 17'd0) begin
            bad++;
            $display("FAIL mid_reset: got en/finish %b count %0d want 00 0", {bs.en, bs.finish}, bs.edge_count);
        end
        total++;
        if (mem_s[101] !== 32'hFF00FF00 || mem_s[102] !== 32'h807FFF00) begin
            bad++;
            $display("FAIL mid_partial: got %h %h want ff00ff00 807fff00", mem_s[101], mem_s[102]);
        end
        reset = 1'b0;
        tick();
        run_small(8'd128, 8'd128, n);
        total++;
        if (n !== 13 || bs.edge_count !== 17'd8) begin
            bad++;
            $display("FAIL mid_restart: got cycles %0d count %0d want 13 8", n, bs.edge_count);
        end
        check_mem4("mid_restart", 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00);
    endtask

    // Entered with start still high from the previous run, DUT sitting in DONE.
    task automatic test_hold_start();
        int busy = 0;
        int lows = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bs.en) busy++;
            if (!bs.finish) lows++;
        end
        total++;
        if (busy != 0 || lows != 0) begin
            bad++;
            $display("FAIL hold_done: got en-cycles %0d finish-low %0d want 0 0", busy, lows);
        end
        bs.start = 1'b0;
        tick();
        total++;
        if (bs.finish !== 1'b0) begin
            bad++;
            $display("FAIL hold_drop: got finish %b want 0", bs.finish);
        end
        repeat (3) tick();
        total++;
        if (bs.en !== 1'b0 || bs.edge_count !== 17'd8) begin
            bad++;
            $display("FAIL hold_idle: got en %b count %0d want 0 8", bs.en, bs.edge_count);
        end
    endtask

    task automatic test_full_image();
        int n = 0;
        int errs = 0;
        int cnt = 0;
        word_t e;
        ld_b = 1'b1;
        tick();
        ld_b = 1'b0;
        bb.thr = 8'd100;
        bb.start = 1'b1;
        tick();
        n = 1;
        bb.thr = 8'd3;
        while (!bb.finish && n < 3 * IMG_WORDS + 100) begin
            tick();
            n++;
        end
        total++;
        if (n !== 3 * IMG_WORDS + 1) begin
            bad++;
            $display("FAIL full_latency: got %0d want %0d", n, 3 * IMG_WORDS + 1);
        end
        for (int k = 0; k < IMG_WORDS; k++) begin
            e = expw(pat(k), 8'd100);
            for (int b = 0; b < 4; b++) cnt += int'(e[8*b]);
            if (mem_b[RES_BASE + k] !== e) begin
                if (errs < 5) $display("FAIL full_word %0d: got %h want %h", k, mem_b[RES_BASE + k], e);
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
        total++;
        if (bb.edge_count !== 17'(cnt)) begin
            bad++;
            $display("FAIL full_count: got %0d want %0d", bb.edge_count, cnt);
        end
        total++;
        if (mem_b[RES_BASE - 1] !== SENT || mem_b[RES_BASE + IMG_WORDS] !== SENT) begin
            bad++;
            $display("FAIL full_bounds: got %h %h want %h", mem_b[RES_BASE - 1], mem_b[RES_BASE + IMG_WORDS], SENT);
        end
        bb.start = 1'b0;
        tick();
    endtask

    initial begin
        bs.start = 1'b0;
        bs.thr   = 8'd0;
        bb.start = 1'b0;
        bb.thr   = 8'd0;
        repeat (2) tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_basic();
        test_thresholds();
        test_bus_sequence();
        test_reset_mid_run();
        test_hold_start();
        test_full_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
